avm_burst_arbiter: RTL and testbench
====================================

Name: avm_burst_arbiter

Overview:
- Shares the single Avalon-MM bursting master port of the SDRAM controller between two requester ports (port 0, port 1). Typical pairing: port 0 = burst write engine, port 1 = burst read/verify engine.
- Arbitration is round-robin.
- A write burst holds the grant until its last beat is accepted.
- A read command releases the grant once accepted. Its return data is routed back by a read-return tracker FIFO.

Parameters:
- ADDR_W, 25, address width.
- DATA_W, 16, data width.
- BURST_W, 8, burstcount width.
- TRK_DEPTH, 4, maximum outstanding read bursts; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- sN_addr  in  ADDR_W  requester address (N = 0, 1; same for all sN_ lines).
- sN_write / sN_read  in  1  requester command strobes; never both high.
- sN_wdata  in  DATA_W  requester write data.
- sN_burstcount  in  BURST_W  beats in the burst; sampled on the first beat.
- sN_waitrequest  out  1  stall to the requester.
- sN_readdata  out  DATA_W  equals avm_readdata (broadcast).
- sN_readdatavalid  out  1  routed read-data valid.
- avm_addr / avm_wdata / avm_burstcount  out  ADDR_W / DATA_W / BURST_W  muxed command to the SDRAM controller.
- avm_write / avm_read  out  1  muxed strobes.
- avm_waitrequest  in  1  stall from the SDRAM controller.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid.
- err_orphan_rdata  out  1  sticky: readdatavalid arrived with the tracker empty.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, on clock clk.
  - state=IDLE, last_grant=1 (so port 0 wins first), tracker empty, err_orphan_rdata=0.
  - All avm_* strobes 0; all sN_waitrequest=1; all sN_readdatavalid=0.
- Eligibility: a port is eligible when its write is high, or its read is high and the tracker is not full.
- IDLE:
  - No master strobes asserted; both sN_waitrequest=1.
  - If any port is eligible: grant <= winner, go to GRANTED.
  - Winner: the single eligible port; if both are eligible, the port != last_grant.
  - One cycle of arbitration latency from request to command on avm_*.
- GRANTED:
  - avm_* combinationally mirrors the granted port; granted sN_waitrequest = avm_waitrequest; the other port's waitrequest=1.
  - Accept = strobe high and avm_waitrequest low.
  - Read accepted: push {port, burstcount} into the tracker, last_grant <= grant, go to IDLE.
  - Write accepted with burstcount 1: last_grant <= grant, go to IDLE.
  - Write accepted with burstcount > 1: beat_cnt <= burstcount-1, go to BURST.
  - Granted port drops both strobes before acceptance: go to IDLE, last_grant unchanged.
- BURST:
  - Grant is held; the requester may deassert write between beats.
  - Each accepted beat decrements beat_cnt.
  - Accepted beat with beat_cnt==1: last_grant <= grant, go to IDLE.
  - The other port stays stalled for the whole burst.
- burstcount 0 is treated as 1 everywhere.
- Read return:
  - On avm_readdatavalid, assert sN_readdatavalid for the tracker head's port in the same cycle (combinational); decrement the head's remaining count.
  - The beat that brings the count to 0 pops the head.
  - Push and pop in the same cycle are legal when full or empty; occupancy is unchanged on a simultaneous push and pop.
- avm_readdatavalid with the tracker empty: drop the data, set err_orphan_rdata (cleared only by reset).
- Reset mid-burst or with reads outstanding: abandon everything and return to the reset state; late readdatavalid then raises err_orphan_rdata.

Optional Feature:
- Macro AVM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are eligible; last_grant is ignored. Bursts are still atomic.
- Undefined: round-robin as described above.

Decomposition:
- Shared package avm_arb_pkg:
  - State encoding localparams ST_IDLE, ST_GRANTED, ST_BURST.
  - Port-ID width constant.
  - Tracker entry width (1 + BURST_W).
- Sub-module avm_rd_tracker: synchronous FIFO of {port, remaining} with head decrement on each beat and pop on the last beat. Outputs full, empty, head_port.

Test Plan:
- s0 write, burstcount 32, no waitrequest -> 32 beats on avm in consecutive cycles after 1 arbitration cycle; s1 write held the whole time sees s1_waitrequest=1 and is granted only after beat 32.
- Both ports issue read burstcount 4 in the same cycle after reset -> port 0 command first, port 1 next; 8 readdatavalid beats route 4 to s0 then 4 to s1.
- TRK_DEPTH=4 reads outstanding with no return data, s1 read pending -> s1 not granted until the first burst fully returns; then granted next cycle.
- avm_waitrequest toggling 1,0,1,0 during s0 write burst of 8 -> exactly 8 accepted beats, wdata order preserved, grant not lost.
- readdatavalid pulse with no outstanding read -> err_orphan_rdata=1 and stays high; no sN_readdatavalid.
- AVM_ARB_FIXED_PRIO_EN defined, both ports continuously issue burstcount-1 writes -> s0 wins every arbitration; undefined -> alternates s0,s1,s0,s1.

Source files
------------

// File: rtl/avm_arb_pkg.sv
// Shared state encoding and sizing constants for the Avalon-MM burst arbiter.
package avm_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_BURST   = 2'd2
   } arb_state_t;

   localparam int PORT_ID_W = 1;

   // A tracker entry is {port, remaining beats}.
   function automatic int trk_entry_w(input int burst_w);
      return PORT_ID_W + burst_w;
   endfunction

endpackage

// File: rtl/avm_rd_tracker.sv
// Read-return tracker: FIFO of {port, remaining beats} for outstanding read bursts.
// The head count decrements on every returned beat and the entry pops on its last beat.
module avm_rd_tracker
   import avm_arb_pkg::*;
#(
   parameter int BURST_W = 8,
   parameter int DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [PORT_ID_W-1:0] push_port,
   input  logic [BURST_W-1:0]   push_count,
   input  logic                 beat,
   output logic                 full,
   output logic                 empty,
   output logic [PORT_ID_W-1:0] head_port
);

   localparam int ENTRY_W = trk_entry_w(BURST_W);
   localparam int PTR_W   = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W:0]     count;
   logic [BURST_W-1:0] head_remaining;
   logic               pop;
   logic               do_push;

   assign empty          = (count == '0);
   assign full           = (count == (PTR_W+1)'(DEPTH));
   assign head_port      = mem[rd_ptr][ENTRY_W-1 -: PORT_ID_W];
   assign head_remaining = mem[rd_ptr][BURST_W-1:0];
   assign pop            = beat && !empty && (head_remaining <= BURST_W'(1));
   // A full tracker may still accept a push when its head retires in the same cycle.
   assign do_push        = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (beat && !empty && !pop)
            mem[rd_ptr][BURST_W-1:0] <= head_remaining - 1'b1;
         if (do_push) begin
            mem[wr_ptr] <= {push_port, (push_count == '0) ? BURST_W'(1) : push_count};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
      end
   end

endmodule

// File: rtl/avm_burst_arbiter.sv
// Shares one Avalon-MM bursting master between two requesters; writes hold the grant per burst.
// Round-robin by default; define AVM_ARB_FIXED_PRIO_EN to make port 0 win every contest.
module avm_burst_arbiter
   import avm_arb_pkg::*;
#(
   parameter int ADDR_W    = 25,
   parameter int DATA_W    = 16,
   parameter int BURST_W   = 8,
   parameter int TRK_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  s0_addr,
   input  logic               s0_write,
   input  logic               s0_read,
   input  logic [DATA_W-1:0]  s0_wdata,
   input  logic [BURST_W-1:0] s0_burstcount,
   output logic               s0_waitrequest,
   output logic [DATA_W-1:0]  s0_readdata,
   output logic               s0_readdatavalid,
   input  logic [ADDR_W-1:0]  s1_addr,
   input  logic               s1_write,
   input  logic               s1_read,
   input  logic [DATA_W-1:0]  s1_wdata,
   input  logic [BURST_W-1:0] s1_burstcount,
   output logic               s1_waitrequest,
   output logic [DATA_W-1:0]  s1_readdata,
   output logic               s1_readdatavalid,
   output logic [ADDR_W-1:0]  avm_addr,
   output logic [DATA_W-1:0]  avm_wdata,
   output logic [BURST_W-1:0] avm_burstcount,
   output logic               avm_write,
   output logic               avm_read,
   input  logic               avm_waitrequest,
   input  logic [DATA_W-1:0]  avm_readdata,
   input  logic               avm_readdatavalid,
   output logic               err_orphan_rdata
);

   arb_state_t             state;
   logic [PORT_ID_W-1:0]   grant;
   logic [PORT_ID_W-1:0]   last_grant;
   logic [PORT_ID_W-1:0]   winner;
   logic [BURST_W-1:0]     beat_cnt;
   logic                   trk_full;
   logic                   trk_empty;
   logic [PORT_ID_W-1:0]   trk_head;
   logic                   elig0;
   logic                   elig1;
   logic                   g_write;
   logic                   g_read;
   logic [BURST_W-1:0]     g_bc;
   logic                   accept_wr;
   logic                   accept_rd;

   // A read is only worth granting if the tracker has room to record its return.
   assign elig0 = s0_write || (s0_read && !trk_full);
   assign elig1 = s1_write || (s1_read && !trk_full);

   always_comb begin
      winner = '0;
`ifdef AVM_ARB_FIXED_PRIO_EN
      winner = elig0 ? PORT_ID_W'(0) : PORT_ID_W'(1);
`else
      if (elig0 && elig1)
         winner = ~last_grant;
      else
         winner = elig1;
`endif
   end

   assign g_write        = grant[0] ? s1_write      : s0_write;
   assign g_read         = grant[0] ? s1_read       : s0_read;
   assign g_bc           = grant[0] ? s1_burstcount : s0_burstcount;
   assign avm_addr       = grant[0] ? s1_addr       : s0_addr;
   assign avm_wdata      = grant[0] ? s1_wdata      : s0_wdata;
   assign avm_burstcount = g_bc;
   assign avm_write      = (state != ST_IDLE) && g_write;
   assign avm_read       = (state == ST_GRANTED) && g_read;
   assign accept_wr      = avm_write && !avm_waitrequest;
   assign accept_rd      = avm_read && !avm_waitrequest;

   assign s0_waitrequest = (state == ST_IDLE) || grant[0]  || avm_waitrequest;
   assign s1_waitrequest = (state == ST_IDLE) || !grant[0] || avm_waitrequest;

   assign s0_readdata      = avm_readdata;
   assign s1_readdata      = avm_readdata;
   assign s0_readdatavalid = avm_readdatavalid && !trk_empty && (trk_head == PORT_ID_W'(0));
   assign s1_readdatavalid = avm_readdatavalid && !trk_empty && (trk_head == PORT_ID_W'(1));

   avm_rd_tracker #(
      .BURST_W (BURST_W),
      .DEPTH   (TRK_DEPTH)
   ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .push       (accept_rd),
      .push_port  (grant),
      .push_count (g_bc),
      .beat       (avm_readdatavalid),
      .full       (trk_full),
      .empty      (trk_empty),
      .head_port  (trk_head)
   );

   // Arbitration FSM: reads and single-beat writes release at once, longer writes hold via BURST.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= PORT_ID_W'(1);
         beat_cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (elig0 || elig1) begin
                  grant <= winner;
                  state <= ST_GRANTED;
               end
            end
            ST_GRANTED: begin
               if (accept_rd) begin
                  last_grant <= grant;
                  state      <= ST_IDLE;
               end else if (accept_wr) begin
                  if (g_bc <= BURST_W'(1)) begin
                     last_grant <= grant;
                     state      <= ST_IDLE;
                  end else begin
                     beat_cnt <= g_bc - 1'b1;
                     state    <= ST_BURST;
                  end
               end else if (!g_write && !g_read) begin
                  state <= ST_IDLE;
               end
            end
            ST_BURST: begin
               if (accept_wr) begin
                  if (beat_cnt == BURST_W'(1)) begin
                     last_grant <= grant;
                     state      <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt - 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Return data with nothing outstanding is dropped and flagged until the next reset.
   always_ff @(posedge clk) begin
      if (reset)
         err_orphan_rdata <= 1'b0;
      else if (avm_readdatavalid && trk_empty)
         err_orphan_rdata <= 1'b1;
   end

endmodule

// File: tb/tb_avm_burst_arbiter.sv
// Self-checking bench for avm_burst_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of grants, bursts and read-return routing.
module tb_avm_burst_arbiter;

   localparam int ADDR_W    = 25;
   localparam int DATA_W    = 16;
   localparam int BURST_W   = 8;
   localparam int TRK_DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   logic [1:0][ADDR_W-1:0]  s_addr;
   logic [1:0]              s_write;
   logic [1:0]              s_read;
   logic [1:0][DATA_W-1:0]  s_wdata;
   logic [1:0][BURST_W-1:0] s_bc;
   logic [1:0]              s_wait;
   logic [1:0][DATA_W-1:0]  s_rdata;
   logic [1:0]              s_rdv;
   logic [ADDR_W-1:0]       avm_addr;
   logic [DATA_W-1:0]       avm_wdata;
   logic [BURST_W-1:0]      avm_burstcount;
   logic                    avm_write;
   logic                    avm_read;
   logic                    avm_waitrequest;
   logic [DATA_W-1:0]       avm_readdata;
   logic                    avm_readdatavalid;
   logic                    err_orphan_rdata;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      int port;
      int left;
   } rd_t;

   rd_t  rdq[$];
   int   txLeft[2];
   int   beatsLeft[2];
   bit   busy[2];
   bit   isWr[2];
   int   drvData[2];
   int   expData[2];
   int   lockPort;
   int   lockLeft;
   int   wrBeats;
   int   expWrBeats;
   int   rdBursts;
   int   expRdBursts;
   logic [1:0] acc;
   bit   done;

   always #5 clk = ~clk;

   avm_burst_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST_W   (BURST_W),
      .TRK_DEPTH (TRK_DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .s0_addr           (s_addr[0]),
      .s0_write          (s_write[0]),
      .s0_read           (s_read[0]),
      .s0_wdata          (s_wdata[0]),
      .s0_burstcount     (s_bc[0]),
      .s0_waitrequest    (s_wait[0]),
      .s0_readdata       (s_rdata[0]),
      .s0_readdatavalid  (s_rdv[0]),
      .s1_addr           (s_addr[1]),
      .s1_write          (s_write[1]),
      .s1_read           (s_read[1]),
      .s1_wdata          (s_wdata[1]),
      .s1_burstcount     (s_bc[1]),
      .s1_waitrequest    (s_wait[1]),
      .s1_readdata       (s_rdata[1]),
      .s1_readdatavalid  (s_rdv[1]),
      .avm_addr          (avm_addr),
      .avm_wdata         (avm_wdata),
      .avm_burstcount    (avm_burstcount),
      .avm_write         (avm_write),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .err_orphan_rdata  (err_orphan_rdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      s_addr = '0; s_write = '0; s_read = '0; s_wdata = '0; s_bc = '0;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic issueRead(input int p, input logic [ADDR_W-1:0] a, input int bc);
      bit ok = 1'b0;
      s_addr[p] = a;
      s_bc[p]   = BURST_W'(bc);
      s_read[p] = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (!s_wait[p] && avm_read && !avm_waitrequest) ok = 1'b1;
         tick();
      end
      s_read[p] = 1'b0;
      checkOutput("read accepted", 32'(ok), 1);
   endtask

   // Random requester behaviour: advance on accepted beats, start new transactions, vary strobes.
   task automatic applyStimulus();
      for (int p = 0; p < 2; p++) begin
         if (acc[p]) begin
            if (isWr[p]) begin
               beatsLeft[p]--;
               drvData[p]++;
               if (beatsLeft[p] == 0) busy[p] = 1'b0;
            end else begin
               busy[p] = 1'b0;
            end
         end
         if (!busy[p] && txLeft[p] > 0 && $urandom_range(0, 3) != 0) begin
            int bc;
            busy[p] = 1'b1;
            txLeft[p]--;
            isWr[p] = 1'($urandom_range(0, 1));
            bc = int'($urandom_range(0, 6));
            s_bc[p] = BURST_W'(bc);
            s_addr[p] = ADDR_W'($urandom);
            beatsLeft[p] = (bc == 0) ? 1 : bc;
            if (isWr[p]) expWrBeats += beatsLeft[p];
            else expRdBursts++;
         end
         s_write[p] = 1'b0;
         s_read[p]  = 1'b0;
         if (busy[p]) begin
            if (isWr[p]) begin
               s_write[p] = ($urandom_range(0, 4) != 0);
               s_wdata[p] = DATA_W'(drvData[p]);
            end else begin
               s_read[p] = 1'b1;
            end
         end
      end
      avm_waitrequest   = ($urandom_range(0, 2) == 0);
      avm_readdatavalid = (rdq.size() > 0) && ($urandom_range(0, 1) == 1);
      avm_readdata      = DATA_W'($urandom);
   endtask

   initial begin
      int accCnt;
      int grants;
      int p;
      int expWinner;
      bit found;

      // Reset state
      resetDut();
      @(negedge clk);
      checkOutput("reset avm_write", 32'(avm_write), 0);
      checkOutput("reset avm_read", 32'(avm_read), 0);
      checkOutput("reset waitrequest", 32'(s_wait), 32'h3);
      checkOutput("reset readdatavalid", 32'(s_rdv), 0);
      checkOutput("reset err_orphan", 32'(err_orphan_rdata), 0);
      tick();

      // 32-beat write from s0 while s1 waits with a single-beat write
      resetDut();
      s_write[0] = 1'b1; s_bc[0] = 8'd32; s_wdata[0] = 16'd0; s_addr[0] = 25'h100;
      s_write[1] = 1'b1; s_bc[1] = 8'd1;  s_wdata[1] = 16'hBEEF; s_addr[1] = 25'h200;
      @(negedge clk);
      checkOutput("A arbitration cycle", 32'(avm_write), 0);
      tick();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         checkOutput("A beat write", 32'(avm_write), 1);
         checkOutput("A beat wdata", 32'(avm_wdata), 32'(i));
         checkOutput("A s1 stalled", 32'(s_wait[1]), 1);
         tick();
         s_wdata[0] = DATA_W'(i + 1);
      end
      s_write[0] = 1'b0;
      @(negedge clk);
      checkOutput("A idle after burst", 32'(avm_write), 0);
      tick();
      @(negedge clk);
      checkOutput("A s1 granted", 32'(s_wait[1]), 0);
      checkOutput("A s1 wdata", 32'(avm_wdata), 32'hBEEF);
      tick();
      s_write[1] = 1'b0;

      // Simultaneous reads of 4 beats from both ports
      resetDut();
      s_read = 2'b11; s_bc[0] = 8'd4; s_bc[1] = 8'd4; s_addr[0] = 25'hA0; s_addr[1] = 25'hA1;
      @(negedge clk);
      checkOutput("B arbitration cycle", 32'(avm_read), 0);
      tick();
      @(negedge clk);
      checkOutput("B first addr", 32'(avm_addr), 32'hA0);
      checkOutput("B s1 stalled", 32'(s_wait[1]), 1);
      tick();
      s_read[0] = 1'b0;
      @(negedge clk);
      checkOutput("B idle between", 32'(avm_read), 0);
      tick();
      @(negedge clk);
      checkOutput("B second addr", 32'(avm_addr), 32'hA1);
      checkOutput("B s1 granted", 32'(s_wait[1]), 0);
      tick();
      s_read[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         avm_readdatavalid = 1'b1;
         avm_readdata = DATA_W'(16'h700 + k);
         @(negedge clk);
         checkOutput("B rdv s0", 32'(s_rdv[0]), 32'(k < 4));
         checkOutput("B rdv s1", 32'(s_rdv[1]), 32'(k >= 4));
         checkOutput("B readdata", 32'(s_rdata[k / 4]), 32'(16'h700 + k));
         tick();
      end
      avm_readdatavalid = 1'b0;
      @(negedge clk);
      checkOutput("B no orphan", 32'(err_orphan_rdata), 0);
      tick();

      // Tracker full blocks further reads until the head burst retires
      resetDut();
      for (int k = 0; k < TRK_DEPTH; k++) issueRead(0, ADDR_W'(25'h300 + k), 2);
      s_read[1] = 1'b1; s_addr[1] = 25'h400; s_bc[1] = 8'd1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("C s1 blocked", 32'(s_wait[1]), 1);
         checkOutput("C no command", 32'(avm_read), 0);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         avm_readdatavalid = 1'b1;
         avm_readdata = DATA_W'(16'hA0 + k);
         @(negedge clk);
         checkOutput("C head to s0", 32'(s_rdv[0]), 1);
         checkOutput("C not to s1", 32'(s_rdv[1]), 0);
         checkOutput("C s1 still blocked", 32'(s_wait[1]), 1);
         tick();
      end
      avm_readdatavalid = 1'b0;
      @(negedge clk);
      checkOutput("C arbitration cycle", 32'(avm_read), 0);
      tick();
      @(negedge clk);
      checkOutput("C s1 granted", 32'(s_wait[1]), 0);
      checkOutput("C s1 addr", 32'(avm_addr), 32'h400);
      checkOutput("C s1 read", 32'(avm_read), 1);
      tick();
      s_read[1] = 1'b0;

      // 8-beat write under alternating waitrequest, s1 contending
      resetDut();
      s_write[0] = 1'b1; s_bc[0] = 8'd8; s_wdata[0] = 16'd100;
      s_write[1] = 1'b1; s_bc[1] = 8'd1; s_wdata[1] = 16'h5555;
      avm_waitrequest = 1'b1;
      accCnt = 0;
      for (int c = 0; c < 40 && accCnt < 8; c++) begin
         bit beat;
         @(negedge clk);
         beat = avm_write && !avm_waitrequest;
         if (accCnt > 0) begin
            checkOutput("D grant held", 32'(s_wait[0]), 32'(avm_waitrequest));
            checkOutput("D s1 stalled", 32'(s_wait[1]), 1);
         end
         if (beat) begin
            checkOutput("D beat wdata", 32'(avm_wdata), 32'(100 + accCnt));
            checkOutput("D beat port", 32'(s_wait[0]), 0);
            accCnt++;
         end
         tick();
         if (beat) s_wdata[0] = s_wdata[0] + 1'b1;
         if (accCnt == 8) s_write[0] = 1'b0;
         avm_waitrequest = ~avm_waitrequest;
      end
      checkOutput("D beats accepted", 32'(accCnt), 8);
      avm_waitrequest = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 4 && !found; c++) begin
         @(negedge clk);
         if (!s_wait[1] && avm_write && avm_wdata == 16'h5555) found = 1'b1;
         tick();
      end
      checkOutput("D s1 granted after burst", 32'(found), 1);
      s_write[1] = 1'b0;

      // Orphan read data, and late data after a reset with reads outstanding
      resetDut();
      avm_readdatavalid = 1'b1; avm_readdata = 16'hDEAD;
      @(negedge clk);
      checkOutput("E no routed rdv", 32'(s_rdv), 0);
      tick();
      avm_readdatavalid = 1'b0;
      @(negedge clk);
      checkOutput("E orphan set", 32'(err_orphan_rdata), 1);
      repeat (3) tick();
      @(negedge clk);
      checkOutput("E orphan sticky", 32'(err_orphan_rdata), 1);
      tick();
      resetDut();
      issueRead(1, 25'h55, 4);
      resetDut();
      @(negedge clk);
      checkOutput("E orphan cleared", 32'(err_orphan_rdata), 0);
      tick();
      avm_readdatavalid = 1'b1;
      @(negedge clk);
      checkOutput("E late data dropped", 32'(s_rdv), 0);
      tick();
      avm_readdatavalid = 1'b0;
      @(negedge clk);
      checkOutput("E late data orphan", 32'(err_orphan_rdata), 1);
      tick();

      // Continuous single-beat writes from both ports: grant order
      resetDut();
      s_write = 2'b11; s_bc[0] = 8'd1; s_bc[1] = 8'd1;
      s_wdata[0] = 16'h1111; s_wdata[1] = 16'h2222;
      grants = 0;
      for (int c = 0; c < 40 && grants < 8; c++) begin
         @(negedge clk);
         if (avm_write && !avm_waitrequest) begin
            p = s_wait[0] ? 1 : 0;
`ifdef AVM_ARB_FIXED_PRIO_EN
            expWinner = 0;
`else
            expWinner = grants % 2;
`endif
            checkOutput("F winner", 32'(p), 32'(expWinner));
            grants++;
         end
         tick();
      end
      checkOutput("F grant count", 32'(grants), 8);

      // Random traffic against the transaction-level model
      resetDut();
      rdq.delete();
      for (int q = 0; q < 2; q++) begin
         txLeft[q] = 20; busy[q] = 1'b0; isWr[q] = 1'b0; beatsLeft[q] = 0;
         drvData[q] = q * 16'h4000; expData[q] = q * 16'h4000;
      end
      lockPort = -1; lockLeft = 0; wrBeats = 0; expWrBeats = 0; rdBursts = 0; expRdBursts = 0;
      acc = '0;
      done = 1'b0;
      applyStimulus();
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         @(negedge clk);
         acc = '0;
         checkOutput("R exclusive grant", 32'(s_wait[0] | s_wait[1]), 1);
         for (int q = 0; q < 2; q++)
            if (!s_wait[q] && (s_write[q] || s_read[q])) acc[q] = 1'b1;
         for (int q = 0; q < 2; q++) begin
            if (acc[q] && s_write[q]) begin
               checkOutput("R write strobe", 32'(avm_write && !avm_read), 1);
               checkOutput("R wdata", 32'(avm_wdata), 32'(DATA_W'(expData[q])));
               expData[q]++;
               if (lockLeft > 0) begin
                  checkOutput("R burst atomic", 32'(q), 32'(lockPort));
                  lockLeft--;
               end else begin
                  lockPort = q;
                  lockLeft = (s_bc[q] == 0) ? 0 : int'(s_bc[q]) - 1;
               end
               wrBeats++;
            end else if (acc[q]) begin
               checkOutput("R read strobe", 32'(avm_read && !avm_write), 1);
               checkOutput("R read addr", 32'(avm_addr), 32'(s_addr[q]));
               checkOutput("R read not mid-burst", 32'(lockLeft), 0);
               rdq.push_back('{q, (s_bc[q] == 0) ? 1 : int'(s_bc[q])});
               checkOutput("R tracker bound", 32'(rdq.size() <= TRK_DEPTH), 1);
               rdBursts++;
            end
         end
         if (avm_readdatavalid && rdq.size() > 0) begin
            checkOutput("R rdv s0", 32'(s_rdv[0]), 32'(rdq[0].port == 0));
            checkOutput("R rdv s1", 32'(s_rdv[1]), 32'(rdq[0].port == 1));
            rdq[0].left = rdq[0].left - 1;
            if (rdq[0].left == 0) void'(rdq.pop_front());
         end else begin
            checkOutput("R no rdv", 32'(s_rdv), 0);
         end
         done = (txLeft[0] == 0) && (txLeft[1] == 0) && !busy[0] && !busy[1]
                && (rdq.size() == 0) && (acc == '0);
         tick();
         applyStimulus();
      end
      checkOutput("R traffic completed", 32'(done), 1);
      checkOutput("R write beats", 32'(wrBeats), 32'(expWrBeats));
      checkOutput("R read bursts", 32'(rdBursts), 32'(expRdBursts));
      checkOutput("R no orphan", 32'(err_orphan_rdata), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
